w3_update_module: RTL and testbench



---
 rtl/w3_update_module.sv | 134 +++++++++++++
 tb/tb_w3_update_module.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/w3_update_module.sv
// Layer-3 weight bank: accumulates scaled delta-weights per weight, then applies w <= w - acc one weight per cycle.
// Optional macro WEIGHT_CLIP_EN clamps each applied weight to [-CLIP_MAG, +CLIP_MAG].
module w3_update_module #(
    parameter int          NUM_W      = 4,
    parameter logic [15:0] INIT_W     = 16'h0400,
    parameter int          ACC_W      = 20,
    parameter logic [3:0]  APPLY_CODE = 4'd10,
`ifdef WEIGHT_CLIP_EN
    parameter logic [15:0] CLIP_MAG   = 16'h1000,
`endif
    localparam int         IW         = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    step,
    input  logic [3:0]    controller,
    input  logic          dw_valid,
    input  logic [IW-1:0] dw_idx,
    input  logic [15:0]   deltaw,
    input  logic [IW-1:0] rd_idx,
    output logic [15:0]   w_rd,
    output logic          busy,
    output logic          upd_done,
    output logic          dw_drop
);

    typedef enum logic [1:0] {IDLE, COLLECT, APPLY, DONE} state_t;

    localparam logic [IW:0]   NUM_W_C = NUM_W[IW:0];
    localparam logic [IW-1:0] LAST_C  = IW'(NUM_W - 1);

    state_t state, state_nxt;

    logic signed [15:0]      w   [NUM_W];
    logic signed [ACC_W-1:0] acc [NUM_W];
    logic [IW-1:0]           cnt;
    logic                    drop_p1;
    logic                    apply_p1;

    logic                    accept;
    logic signed [ACC_W:0]   acc_sum_p0;
    logic signed [ACC_W:0]   diff_p0;
    logic signed [15:0]      new_w_p0;

    // Sum of two ACC_W-bit values fits ACC_W+1 bits, so overflow shows as a sign-bit disagreement.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        if (v[ACC_W] != v[ACC_W-1])
            return v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return v[ACC_W-1:0];
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W:0] v);
        if ((v[ACC_W:15] == '0) || (v[ACC_W:15] == '1))
            return v[15:0];
        return v[ACC_W] ? 16'sh8000 : 16'sh7FFF;
    endfunction

`ifdef WEIGHT_CLIP_EN
    function automatic logic signed [15:0] clip_w(input logic signed [15:0] v);
        logic signed [15:0] mag;
        mag = CLIP_MAG;
        if (v > mag)
            return mag;
        if (v < -mag)
            return -mag;
        return v;
    endfunction
`endif

    assign accept = dw_valid && (state == COLLECT) && (step != 4'd0) && ({1'b0, dw_idx} < NUM_W_C);

    always_comb begin
        acc_sum_p0 = {acc[dw_idx][ACC_W-1], acc[dw_idx]} + {{(ACC_W-15){deltaw[15]}}, deltaw};
        diff_p0    = {{(ACC_W-15){w[cnt][15]}}, w[cnt]} - {acc[cnt][ACC_W-1], acc[cnt]};
`ifdef WEIGHT_CLIP_EN
        new_w_p0   = clip_w(sat16(diff_p0));
`else
        new_w_p0   = sat16(diff_p0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (step != 4'd0) state_nxt = COLLECT;
            COLLECT: if ((controller == APPLY_CODE) && (step != 4'd0)) state_nxt = APPLY;
            APPLY:   if (cnt == LAST_C) state_nxt = DONE;
            DONE:    if (controller != APPLY_CODE) state_nxt = COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == APPLY);
        upd_done = (state == DONE) && apply_p1;
    end

    // Bank, accumulators, read register and event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_W; i++) begin
                w[i]   <= INIT_W;
                acc[i] <= '0;
            end
            w_rd     <= INIT_W;
            cnt      <= '0;
            drop_p1  <= 1'b0;
            apply_p1 <= 1'b0;
        end else begin
            w_rd     <= w[rd_idx];
            drop_p1  <= dw_valid && !accept;
            apply_p1 <= (state == APPLY);
            if (state == APPLY) begin
                w[cnt]   <= new_w_p0;
                acc[cnt] <= '0;
                cnt      <= cnt + IW'(1);
            end else begin
                cnt <= '0;
            end
            if (accept)
                acc[dw_idx] <= sat_acc(acc_sum_p0);
        end
    end

    assign dw_drop = drop_p1;

endmodule

// File: tb/tb_w3_update_module.sv
// Bench for w3_update_module: table of single-index accumulate/apply scenarios plus drop, held-code and mid-apply reset sequences.
module tb_w3_update_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  step;
    logic [3:0]  controller;
    logic        dw_valid;
    logic [1:0]  dw_idx;
    logic [15:0] deltaw;
    logic [1:0]  rd_idx;
    logic [15:0] w_rd;
    logic        busy;
    logic        upd_done;
    logic        dw_drop;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          idx;
        logic [15:0] dw;
        int          beats;
        logic [15:0] exp_w;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    vec_t tbl[5];
    sb_t  sbq[$];

    w3_update_module dut (
        .clk(clk), .rst(rst), .step(step), .controller(controller),
        .dw_valid(dw_valid), .dw_idx(dw_idx), .deltaw(deltaw), .rd_idx(rd_idx),
        .w_rd(w_rd), .busy(busy), .upd_done(upd_done), .dw_drop(dw_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input int k, input logic [15:0] exp, input string tag);
        sb_t item;
        item.name = $sformatf("%s w[%0d]", tag, k);
        item.exp  = exp;
        sbq.push_back(item);
        rd_idx = 2'(k);
        tick();
        item = sbq.pop_front();
        chk(item.name, {16'h0, w_rd}, {16'h0, item.exp});
    endtask

    task automatic read_all(input int k_idx, input logic [15:0] exp_k, input string tag);
        for (int k = 0; k < 4; k++)
            rd_chk(k, (k == k_idx) ? exp_k : 16'h0400, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; step = 4'd0; controller = 4'd0; dw_valid = 1'b0;
        dw_idx = 2'd0; deltaw = 16'h0; rd_idx = 2'd0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic beats(input int idx, input logic [15:0] dw, input int n);
        dw_idx = 2'(idx); deltaw = dw; dw_valid = 1'b1;
        repeat (n) tick();
        dw_valid = 1'b0;
    endtask

    task automatic do_apply(input int hold, input string tag);
        int nb, nd;
        nb = 0; nd = 0;
        controller = 4'd10;
        repeat (hold) begin
            tick();
            nb += int'(busy);
            nd += int'(upd_done);
        end
        controller = 4'd0;
        repeat (2) begin
            tick();
            nb += int'(busy);
            nd += int'(upd_done);
        end
        chk({tag, " busy cycles"}, nb, 4);
        chk({tag, " upd_done pulses"}, nd, 1);
    endtask

    initial begin
        tbl[0] = '{"two_small",   1, 16'h0020, 2,  16'h03C0};
        tbl[2] = '{"one_pos",     0, 16'h0100, 1,  16'h0300};
        tbl[4] = '{"one_neg",     0, 16'hFC00, 1,  16'h0800};
`ifdef WEIGHT_CLIP_EN
        tbl[1] = '{"neg_sat_hi",  2, 16'h8000, 3,  16'h1000};
        tbl[3] = '{"acc_sat_lo",  3, 16'h7FFF, 20, 16'hF000};
`else
        tbl[1] = '{"neg_sat_hi",  2, 16'h8000, 3,  16'h7FFF};
        tbl[3] = '{"acc_sat_lo",  3, 16'h7FFF, 20, 16'h8000};
`endif

        // Reset state
        do_reset();
        chk("reset busy", {31'h0, busy}, 0);
        chk("reset upd_done", {31'h0, upd_done}, 0);
        chk("reset dw_drop", {31'h0, dw_drop}, 0);
        read_all(-1, 16'h0400, "reset");

        // Table-driven accumulate/apply scenarios
        foreach (tbl[i]) begin
            do_reset();
            step = 4'd1;
            tick();
            beats(tbl[i].idx, tbl[i].dw, tbl[i].beats);
            chk({tbl[i].name, " accepted no drop"}, {31'h0, dw_drop}, 0);
            do_apply(8, tbl[i].name);
            read_all(tbl[i].idx, tbl[i].exp_w, tbl[i].name);
        end

        // Held APPLY_CODE fires once; re-arm after a different code; accumulator was cleared
        do_reset();
        step = 4'd1;
        tick();
        beats(1, 16'h0020, 2);
        do_apply(10, "held");
        read_all(1, 16'h03C0, "held");
        controller = 4'd4;
        repeat (2) tick();
        do_apply(8, "rearm");
        read_all(1, 16'h03C0, "rearm");

        // Beats during APPLY and with step == 0 are dropped
        do_reset();
        step = 4'd1;
        tick();
        controller = 4'd10;
        tick();
        tick();
        dw_idx = 2'd0; deltaw = 16'h0100; dw_valid = 1'b1;
        tick();
        dw_valid = 1'b0;
        chk("drop in apply", {31'h0, dw_drop}, 1);
        repeat (4) tick();
        controller = 4'd0;
        tick();
        step = 4'd0;
        dw_idx = 2'd1; deltaw = 16'h0100; dw_valid = 1'b1;
        tick();
        dw_valid = 1'b0;
        chk("drop step0", {31'h0, dw_drop}, 1);
        tick();
        chk("drop pulse ends", {31'h0, dw_drop}, 0);
        step = 4'd1;
        do_apply(8, "after drops");
        read_all(-1, 16'h0400, "after drops");

        // Reset on the third APPLY cycle reverts everything
        do_reset();
        step = 4'd1;
        tick();
        for (int k = 0; k < 4; k++)
            beats(k, 16'h0040, 1);
        controller = 4'd10;
        repeat (3) tick();
        chk("mid-apply busy before rst", {31'h0, busy}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        step = 4'd0;
        chk("rst busy", {31'h0, busy}, 0);
        chk("rst upd_done", {31'h0, upd_done}, 0);
        begin
            int nb;
            nb = 0;
            repeat (3) begin
                tick();
                nb += int'(busy);
            end
            chk("idle ignores code", nb, 0);
        end
        controller = 4'd0;
        read_all(-1, 16'h0400, "rst mid");
        step = 4'd1;
        tick();
        do_apply(8, "post rst");
        read_all(-1, 16'h0400, "post rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
